// File: rtl/frv_rvfi_trace.sv
// frv_rvfi_trace: RVFI trace producer; operands captured at register-read, merged with writeback at retire.
// Optional rs3 capture is enabled by defining RVFI_RS3_EN.
module frv_rvfi_trace #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic              g_clk,
    input  logic              g_reset,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [31:0]       id_insn,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1_addr,
    input  logic [XLEN-1:0]   id_rs1_rdata,
    input  logic [4:0]        id_rs2_addr,
    input  logic [XLEN-1:0]   id_rs2_rdata,
    input  logic [4:0]        id_rs3_addr,
    input  logic [XLEN-1:0]   id_rs3_rdata,
    input  logic              wb_valid,
    input  logic              wb_trap,
    input  logic [4:0]        wb_rd_addr,
    input  logic [XLEN-1:0]   wb_rd_wdata,
    input  logic              wb_rd_wide,
    input  logic [XLEN-1:0]   wb_rd_wdatahi,
    input  logic [XLEN-1:0]   wb_pc_wdata,
    input  logic [XLEN-1:0]   wb_mem_addr,
    input  logic [XLEN/8-1:0] wb_mem_rmask,
    input  logic [XLEN/8-1:0] wb_mem_wmask,
    input  logic [XLEN-1:0]   wb_mem_rdata,
    input  logic [XLEN-1:0]   wb_mem_wdata,
    input  logic              flush,
    output logic              rvfi_valid,
    output logic [63:0]       rvfi_order,
    output logic [31:0]       rvfi_insn,
    output logic              rvfi_trap,
    output logic [XLEN-1:0]   rvfi_pc_rdata,
    output logic [XLEN-1:0]   rvfi_pc_wdata,
    output logic [4:0]        rvfi_rs1_addr,
    output logic [XLEN-1:0]   rvfi_rs1_rdata,
    output logic [4:0]        rvfi_rs2_addr,
    output logic [XLEN-1:0]   rvfi_rs2_rdata,
    output logic [4:0]        rvfi_rs3_addr,
    output logic [XLEN-1:0]   rvfi_rs3_rdata,
    output logic [4:0]        rvfi_rd_addr,
    output logic [XLEN-1:0]   rvfi_rd_wdata,
    output logic              rvfi_rd_wide,
    output logic [XLEN-1:0]   rvfi_rd_wdatahi,
    output logic [XLEN-1:0]   rvfi_mem_addr,
    output logic [XLEN/8-1:0] rvfi_mem_rmask,
    output logic [XLEN/8-1:0] rvfi_mem_wmask,
    output logic [XLEN-1:0]   rvfi_mem_rdata,
    output logic [XLEN-1:0]   rvfi_mem_wdata,
    output logic              trace_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [63:0]     cnt_q;
    logic            full, empty, push, pop;
    logic [AW-1:0]   h;
    logic [31:0]     insn_q [DEPTH];
    logic [XLEN-1:0] pc_q [DEPTH];
    logic [4:0]      rs1a_q [DEPTH];
    logic [4:0]      rs2a_q [DEPTH];
    logic [XLEN-1:0] rs1d_q [DEPTH];
    logic [XLEN-1:0] rs2d_q [DEPTH];

    assign full     = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
    assign empty    = wr_q == rd_q;
    assign id_ready = !full;
    assign push     = id_valid & id_ready & !flush;
    assign pop      = wb_valid & !empty;
    assign h        = rd_q[AW-1:0];

    always_comb begin
        wr_d = flush ? '0 : wr_q + PW'(push);
        rd_d = flush ? '0 : rd_q + PW'(pop);
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Entry storage needs no reset: the pointers alone define what is live.
    always_ff @(posedge g_clk) begin
        if (push) begin
            insn_q[wr_q[AW-1:0]] <= id_insn;
            pc_q[wr_q[AW-1:0]]   <= id_pc;
            rs1a_q[wr_q[AW-1:0]] <= id_rs1_addr;
            rs1d_q[wr_q[AW-1:0]] <= id_rs1_rdata;
            rs2a_q[wr_q[AW-1:0]] <= id_rs2_addr;
            rs2d_q[wr_q[AW-1:0]] <= id_rs2_rdata;
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            cnt_q           <= '0;
            trace_err       <= 1'b0;
            rvfi_valid      <= 1'b0;
            rvfi_order      <= '0;
            rvfi_insn       <= '0;
            rvfi_trap       <= 1'b0;
            rvfi_pc_rdata   <= '0;
            rvfi_pc_wdata   <= '0;
            rvfi_rs1_addr   <= '0;
            rvfi_rs1_rdata  <= '0;
            rvfi_rs2_addr   <= '0;
            rvfi_rs2_rdata  <= '0;
            rvfi_rd_addr    <= '0;
            rvfi_rd_wdata   <= '0;
            rvfi_rd_wide    <= 1'b0;
            rvfi_rd_wdatahi <= '0;
            rvfi_mem_addr   <= '0;
            rvfi_mem_rmask  <= '0;
            rvfi_mem_wmask  <= '0;
            rvfi_mem_rdata  <= '0;
            rvfi_mem_wdata  <= '0;
        end else begin
            rvfi_valid <= pop;
            trace_err  <= trace_err | (wb_valid & empty);
            if (pop) begin
                cnt_q           <= cnt_q + 64'd1;
                rvfi_order      <= cnt_q;
                rvfi_insn       <= insn_q[h];
                rvfi_trap       <= wb_trap;
                rvfi_pc_rdata   <= pc_q[h];
                rvfi_pc_wdata   <= wb_pc_wdata;
                rvfi_rs1_addr   <= rs1a_q[h];
                rvfi_rs1_rdata  <= rs1d_q[h];
                rvfi_rs2_addr   <= rs2a_q[h];
                rvfi_rs2_rdata  <= rs2d_q[h];
                rvfi_rd_addr    <= wb_trap ? '0 : wb_rd_addr;
                rvfi_rd_wdata   <= (wb_trap || wb_rd_addr == '0) ? '0 : wb_rd_wdata;
                rvfi_rd_wide    <= wb_rd_wide;
                rvfi_rd_wdatahi <= (wb_trap || !wb_rd_wide) ? '0 : wb_rd_wdatahi;
                rvfi_mem_addr   <= wb_mem_addr;
                rvfi_mem_rmask  <= wb_trap ? '0 : wb_mem_rmask;
                rvfi_mem_wmask  <= wb_trap ? '0 : wb_mem_wmask;
                rvfi_mem_rdata  <= wb_mem_rdata;
                rvfi_mem_wdata  <= wb_mem_wdata;
            end
        end
    end

`ifdef RVFI_RS3_EN
    logic [4:0]      rs3a_q [DEPTH];
    logic [XLEN-1:0] rs3d_q [DEPTH];

    always_ff @(posedge g_clk) begin
        if (push) begin
            rs3a_q[wr_q[AW-1:0]] <= id_rs3_addr;
            rs3d_q[wr_q[AW-1:0]] <= id_rs3_rdata;
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            rvfi_rs3_addr  <= '0;
            rvfi_rs3_rdata <= '0;
        end else if (pop) begin
            rvfi_rs3_addr  <= rs3a_q[h];
            rvfi_rs3_rdata <= rs3d_q[h];
        end
    end
`else
    logic unused_rs3;
    assign unused_rs3     = ^{id_rs3_addr, id_rs3_rdata};
    assign rvfi_rs3_addr  = '0;
    assign rvfi_rs3_rdata = '0;
`endif
endmodule
